// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, frame sizing and command codes for the host transmitter and scan-code receiver.
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE, ERROR} state_t;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] BREAK       = 8'hF0;

    // Bits following the start bit, LSB first: data, odd parity, stop.
    function automatic logic [FRAME_LEN-2:0] tx_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer for the PS/2 clock and data lines plus a falling-edge pulse on clock.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic kb_clk_in,
    input  logic kb_data_in,
    output logic clk_s,
    output logic data_s,
    output logic fall
);

    logic [2:0] c;
    logic [1:0] d;

    // Reset to the idle-high line level so reset alone never produces an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            c <= '1;
            d <= '1;
        end else begin
            c <= {c[1:0], kb_clk_in};
            d <= {d[0], kb_data_in};
        end
    end

    assign clk_s  = c[1];
    assign data_s = d[1];
    assign fall   = c[2] & ~c[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-collector lines through active-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kb_clk_in,
    input  logic       kb_data_in,
    output logic       kb_clk_oe,
    output logic       kb_data_oe,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [3:0]           bit_cnt, bit_cnt_d;
    logic [FRAME_LEN-2:0] frame;
    logic                 clk_s, data_s, fall;
    logic                 line_active, send_fall, timed_out;
    logic                 clk_oe_d, data_oe_d;

    ps2_line_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .kb_clk_in  (kb_clk_in),
        .kb_data_in (kb_data_in),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .fall       (fall)
    );

    assign line_active = state inside {REQ, SEND, ACK, WAIT_IDLE};
    assign send_fall   = fall && (state == REQ || state == SEND);
    // A fall in the expiry cycle keeps the frame alive.
    assign timed_out   = line_active && !fall && cnt == TO_LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            kb_clk_oe  <= 1'b0;
            kb_data_oe <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_cnt    <= bit_cnt_d;
            frame      <= (state == IDLE && tx_start) ? tx_frame(tx_data) : frame;
            kb_clk_oe  <= clk_oe_d;
            kb_data_oe <= data_oe_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (tx_start) state_d = INHIBIT;
            INHIBIT:   if (cnt == INH_LAST) state_d = REQ;
            REQ:       if (fall) state_d = SEND;
            SEND:      if (fall && bit_cnt == 4'd9) state_d = ACK;
            ACK:       if (fall) state_d = data_s ? ERROR : WAIT_IDLE;
            WAIT_IDLE: if (clk_s && data_s) state_d = DONE;
            default:   state_d = IDLE;
        endcase
        if (timed_out && state_d == state) state_d = ERROR;
    end

    // Our own clock pull-down during INHIBIT shows up as a fall and must not restart the count.
    always_comb begin
        cnt_d     = (state == IDLE || state_d != state || (fall && state != INHIBIT)) ? '0 : cnt + 1'b1;
        bit_cnt_d = state_d == REQ ? 4'd0 : send_fall ? bit_cnt + 4'd1 : bit_cnt;
        clk_oe_d  = state_d == INHIBIT;
        data_oe_d = (state_d inside {REQ, SEND, ACK, WAIT_IDLE})
                  ? (send_fall ? ~frame[bit_cnt] : kb_data_oe)
                  : (state_d == INHIBIT && cnt_d == INH_LAST);
        tx_busy   = state inside {INHIBIT, REQ, SEND, ACK, WAIT_IDLE};
        tx_done   = state == DONE;
        tx_error  = state == ERROR;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a device-side PS/2 model on wired-AND lines.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TO   = 500;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] d;
        int         done;
        int         err;
        int         done0;
        int         err0;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       kb_clk_in, kb_data_in, kb_clk_oe, kb_data_oe;
    logic       tx_busy, tx_done, tx_error;
    logic [9:0] rx_bits;
    bit         rx_full;
    exp_t       sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_done = 0;
    int         n_err = 0;

    assign kb_clk_in  = dev_clk & ~kb_clk_oe;
    assign kb_data_in = dev_data & ~kb_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .kb_clk_in  (kb_clk_in),
        .kb_data_in (kb_data_in),
        .kb_clk_oe  (kb_clk_oe),
        .kb_data_oe (kb_data_oe),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always @(posedge clk) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_error) n_err <= n_err + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Only an idle transmitter accepts a request; the scoreboard records just the accepted ones.
    task automatic start(input logic [7:0] b, input int done, input int err);
        exp_t e;
        tx_data  = b;
        tx_start = 1'b1;
        if (!tx_busy && !tx_done && !tx_error) begin
            e.d = b; e.done = done; e.err = err; e.done0 = n_done; e.err0 = n_err;
            sb.push_back(e);
        end
        tick(1);
        tx_start = 1'b0;
    endtask

    task automatic inhibit(output int len);
        len = 0;
        for (int i = 0; i < INH + 50; i++) begin
            if (kb_clk_oe) len++;
            else if (len > 0) break;
            tick(1);
        end
    endtask

    task automatic dev_frame(input int ack, input int stop_at, input int rst_at);
        int n;
        rx_full = 0;
        tick(4);
        check_eq("req_lines", int'({kb_clk_in, kb_data_in}), 2);
        for (int f = 1; f <= 10; f++) begin
            dev_clk = 1'b0;
            if (f == stop_at) begin
                for (n = 1; n < TO + 50; n++) begin
                    tick(1);
                    if (tx_error) break;
                end
                check_eq("fall_timeout", n, TO + 3);
                dev_clk = 1'b1;
                return;
            end
            if (f == rst_at) begin
                reset = 1'b1;
                tick(1);
                check_eq("rst_outs", int'({kb_clk_oe, kb_data_oe, tx_busy, tx_done, tx_error}), 0);
                check_eq("rst_state", int'(dut.state), int'(IDLE));
                reset = 1'b0;
                dev_clk = 1'b1;
                return;
            end
            tick(HALF);
            rx_bits[f-1] = kb_data_in;
            dev_clk = 1'b1;
            tick(HALF);
        end
        rx_full = 1;
        dev_data = ack ? 1'b0 : 1'b1;
        tick(5);
        dev_clk = 1'b0;
        tick(HALF);
        dev_clk = 1'b1;
        tick(10);
        dev_data = 1'b1;
        tick(HALF);
    endtask

    task automatic finish_tx();
        exp_t e;
        int   k;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (rx_full) begin
            check_eq("data", int'(rx_bits[7:0]), int'(e.d));
            check_eq("parity", int'(rx_bits[8]), int'(~^e.d));
            check_eq("stop", int'(rx_bits[9]), 1);
        end
        if (e.done + e.err > 0) begin
            for (k = 0; k < 1000 && n_done + n_err == e.done0 + e.err0; k++) tick(1);
            check_eq("outcome_wait", int'(k < 1000), 1);
        end else begin
            tick(60);
        end
        check_eq("done_cnt", n_done - e.done0, e.done);
        check_eq("err_cnt", n_err - e.err0, e.err);
        tick(2);
        check_eq("released", int'({kb_clk_oe, kb_data_oe, tx_busy}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int len;
        int n;
        logic [7:0] pat [2];
        int         par [2];
        pat[0] = 8'h07; par[0] = 0;
        pat[1] = 8'h00; par[1] = 1;

        tick(3);
        check_eq("reset_outs", int'({kb_clk_oe, kb_data_oe, tx_busy, tx_done, tx_error}), 0);
        reset = 1'b0;
        tick(2);

        start(CMD_SET_LED, 1, 0);
        inhibit(len);
        check_eq("inhibit_len", len, INH);
        check_eq("start_bit_oe", int'(kb_data_oe), 1);
        dev_frame(1, 0, 0);
        check_eq("ed_frame", int'(rx_bits), 'h3ED);
        finish_tx();

        for (int i = 0; i < 2; i++) begin
            tick(10);
            start(pat[i], 1, 0);
            inhibit(len);
            dev_frame(1, 0, 0);
            check_eq("parity_pat", int'(rx_bits[8]), par[i]);
            finish_tx();
        end

        tick(10);
        start(8'h5A, 0, 1);
        inhibit(len);
        dev_frame(0, 0, 0);
        finish_tx();

        tick(10);
        start(CMD_RESET, 0, 1);
        inhibit(len);
        rx_full = 0;
        for (n = 1; n < TO + 50; n++) begin
            tick(1);
            if (tx_error) break;
        end
        check_eq("req_timeout", n, TO);
        finish_tx();

        tick(10);
        start(8'hA5, 0, 1);
        inhibit(len);
        dev_frame(1, 4, 0);
        finish_tx();

        tick(10);
        start(CMD_SET_LED, 1, 0);
        fork
            begin
                inhibit(len);
                dev_frame(1, 0, 0);
            end
            begin
                tick(150);
                check_eq("busy_mid", int'(tx_busy), 1);
                start(CMD_ENABLE, 1, 0);
                check_eq("sb_depth", sb.size(), 1);
            end
        join
        finish_tx();
        tick(10);
        start(CMD_ENABLE, 1, 0);
        inhibit(len);
        dev_frame(1, 0, 0);
        finish_tx();

        tick(10);
        start(CMD_RESET, 0, 0);
        inhibit(len);
        dev_frame(1, 0, 5);
        finish_tx();
        tick(10);
        start(CMD_RESET, 1, 0);
        inhibit(len);
        check_eq("inhibit_len2", len, INH);
        dev_frame(1, 0, 0);
        finish_tx();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
